// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: request direction, FSM encoding, IO address tag.
package mem_arbiter_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [1:0] IO_ADDR_TAG = 2'b11;
    localparam logic [2:0] WORD_BYTES  = 3'd4;

    // Stores into the UART window must wait while the transmitter is full.
    function automatic logic is_io_store(input logic rw, input logic [1:0] tag,
                                         input logic [1:0] io_tag);
        return (rw == RW_WRITE) && (tag == io_tag);
    endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// One pending-request register. A clear (grant or flush) beats a load in the same cycle;
// the top only asserts both when the incoming request is the one being consumed.
module mem_arb_slot #(
    parameter int PAY_W = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             load,
    input  logic             clr,
    input  logic [PAY_W-1:0] d,
    output logic             vld,
    output logic [PAY_W-1:0] q
);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (rdy_in) begin
            if (clr) begin
                vld <= 1'b0;
            end else if (load) begin
                vld <= 1'b1;
                q   <= d;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory-controller port between the instruction fetcher and the LSU.
// Request pulses land in pending slots; one downstream operation is outstanding at a time.
module mem_arbiter #(
    parameter int         ADDR_W       = 32,
    parameter int         DATA_W       = 32,
    parameter int         STARVE_LIMIT = 4,
    parameter logic [1:0] IO_ADDR_TAG  = mem_arbiter_pkg::IO_ADDR_TAG
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              fetch_en_in,
    input  logic [ADDR_W-1:0] fetch_pc_in,
    input  logic              drop_in,
    output logic              fetch_done_out,
    output logic [DATA_W-1:0] fetch_inst_out,
    input  logic              ls_en_in,
    input  logic              ls_rw_in,
    input  logic [ADDR_W-1:0] ls_addr_in,
    input  logic [DATA_W-1:0] ls_wdata_in,
    input  logic [2:0]        ls_size_in,
    output logic              ls_done_out,
    output logic [DATA_W-1:0] ls_rdata_out,
    input  logic              uart_full_in,
    output logic              mc_req_out,
    output logic              mc_rw_out,
    output logic [ADDR_W-1:0] mc_addr_out,
    output logic [DATA_W-1:0] mc_wdata_out,
    output logic [2:0]        mc_size_out,
    input  logic              mc_done_in,
    input  logic [DATA_W-1:0] mc_rdata_in
);
    import mem_arbiter_pkg::*;

    localparam int         LS_W       = 1 + 3 + DATA_W + ADDR_W;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       inflight_fetch;
    logic       inflight_rw;

    logic              f_vld, f_load, f_clr, f_pend;
    logic [ADDR_W-1:0] f_q, f_eff_pc;

    logic              l_vld, l_load, l_clr, l_pend, l_ok, l_q_rw;
    logic [LS_W-1:0]   l_din, l_q, l_eff;
    logic              l_rw;
    logic [2:0]        l_size;
    logic [DATA_W-1:0] l_data;
    logic [ADDR_W-1:0] l_addr;

    logic idle, grant_f, grant_l, kill_resp;

    // Effective request = this cycle's pulse if present, else the stored slot.
    // A flush removes fetches and loads from both sources but leaves stores alone.
    assign f_load   = fetch_en_in && !drop_in;
    assign f_pend   = f_load || (f_vld && !drop_in);
    assign f_eff_pc = f_load ? fetch_pc_in : f_q;
    assign f_clr    = grant_f || drop_in;

    assign l_din  = {ls_rw_in, ls_size_in, ls_wdata_in, ls_addr_in};
    assign l_q_rw = l_q[LS_W-1];
    assign l_load = ls_en_in && !(drop_in && ls_rw_in == RW_READ);
    assign l_eff  = l_load ? l_din : l_q;
    assign {l_rw, l_size, l_data, l_addr} = l_eff;
    assign l_pend = l_load || (l_vld && !(drop_in && l_q_rw == RW_READ));
    assign l_clr  = grant_l || (drop_in && l_q_rw == RW_READ && !l_load);

    assign l_ok = l_pend && !(uart_full_in && is_io_store(l_rw, l_addr[17:16], IO_ADDR_TAG));

    assign idle    = (state == ST_IDLE);
    assign grant_f = idle && f_pend && (!l_ok || starve_cnt == STARVE_MAX);
    assign grant_l = idle && l_ok && !grant_f;

    // Reads in flight are abandoned on a flush; stores always complete and respond.
    assign kill_resp = inflight_fetch || inflight_rw == RW_READ;

    mem_arb_slot #(.PAY_W(ADDR_W)) u_fetch_slot (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .load     (f_load),
        .clr      (f_clr),
        .d        (fetch_pc_in),
        .vld      (f_vld),
        .q        (f_q)
    );

    mem_arb_slot #(.PAY_W(LS_W)) u_ls_slot (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .load     (l_load),
        .clr      (l_clr),
        .d        (l_din),
        .vld      (l_vld),
        .q        (l_q)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= ST_IDLE;
            starve_cnt     <= '0;
            inflight_fetch <= 1'b0;
            inflight_rw    <= RW_READ;
            mc_req_out     <= 1'b0;
            mc_rw_out      <= RW_READ;
            mc_addr_out    <= '0;
            mc_wdata_out   <= '0;
            mc_size_out    <= '0;
            fetch_done_out <= 1'b0;
            fetch_inst_out <= '0;
            ls_done_out    <= 1'b0;
            ls_rdata_out   <= '0;
        end else if (rdy_in) begin
            mc_req_out     <= 1'b0;
            fetch_done_out <= 1'b0;
            ls_done_out    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_f || grant_l) begin
                        state          <= ST_BUSY;
                        mc_req_out     <= 1'b1;
                        inflight_fetch <= grant_f;
                        inflight_rw    <= grant_f ? RW_READ : l_rw;
                        mc_rw_out      <= grant_f ? RW_READ : l_rw;
                        mc_addr_out    <= grant_f ? f_eff_pc : l_addr;
                        mc_wdata_out   <= grant_f ? '0 : l_data;
                        mc_size_out    <= grant_f ? WORD_BYTES : l_size;
                    end
                    if (grant_f)
                        starve_cnt <= '0;
                    else if (grant_l && f_pend)
                        starve_cnt <= starve_cnt + 4'd1;
                end
                ST_BUSY: begin
                    if (mc_done_in) begin
                        state <= ST_IDLE;
                        if (!kill_resp) begin
                            ls_done_out  <= 1'b1;
                            ls_rdata_out <= '0;
                        end else if (!drop_in) begin
                            if (inflight_fetch) begin
                                fetch_done_out <= 1'b1;
                                fetch_inst_out <= mc_rdata_in;
                            end else begin
                                ls_done_out  <= 1'b1;
                                ls_rdata_out <= mc_rdata_in;
                            end
                        end
                    end else if (drop_in && kill_resp) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (mc_done_in)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
